// File: rtl/id_scan_pkg.sv
// Shared encodings for the identifier scanner: character classes, FSM states
// and the ASCII ranges that define letters and digits.
package id_scan_pkg;

   typedef enum logic [1:0] {
      CLS_SEP   = 2'd0,
      CLS_ALPHA = 2'd1,
      CLS_DIGIT = 2'd2
   } char_cls_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ALPHA = 2'd1,
      S_DIGIT = 2'd2,
      S_BAD   = 2'd3
   } state_t;

   localparam logic [7:0] ASCII_UP_A       = 8'd65;
   localparam logic [7:0] ASCII_UP_Z       = 8'd90;
   localparam logic [7:0] ASCII_LO_A       = 8'd97;
   localparam logic [7:0] ASCII_LO_Z       = 8'd122;
   localparam logic [7:0] ASCII_UNDERSCORE = 8'd95;
   localparam logic [7:0] ASCII_0          = 8'd48;
   localparam logic [7:0] ASCII_9          = 8'd57;

   function automatic logic in_range(input logic [7:0] c,
                                     input logic [7:0] lo,
                                     input logic [7:0] hi);
      return (c >= lo) && (c <= hi);
   endfunction

endpackage

// File: rtl/id_scan_char_class.sv
// Combinational classifier: maps one ASCII character to letter, digit or separator.
module char_class
   import id_scan_pkg::*;
#(
   parameter int UNDERSCORE_ALPHA = 0
) (
   input  logic [7:0] char,
   output char_cls_t  cls
);

   logic is_alpha;
   logic is_digit;

   assign is_digit = in_range(char, ASCII_0, ASCII_9);
   assign is_alpha = in_range(char, ASCII_UP_A, ASCII_UP_Z)
                  || in_range(char, ASCII_LO_A, ASCII_LO_Z)
                  || ((UNDERSCORE_ALPHA != 0) && (char == ASCII_UNDERSCORE));

   always_comb begin
      cls = CLS_SEP;
      if (is_digit) begin
         cls = CLS_DIGIT;
      end else if (is_alpha) begin
         cls = CLS_ALPHA;
      end
   end

endmodule

// File: rtl/id_scan_fsm.sv
// Streaming recogniser for tokens of the form letter{MIN_ALPHA..} digit{1..MAX_DIGIT},
// with legacy suffix or strict whole-token matching and a saturating token counter.
module id_scan_fsm
   import id_scan_pkg::*;
#(
   parameter int MIN_ALPHA        = 1,
   parameter int MAX_DIGIT        = 0,
   parameter int STRICT           = 0,
   parameter int UNDERSCORE_ALPHA = 0,
   parameter int CNT_W            = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             char_valid,
   input  logic [7:0]       char,
   output logic             out,
   output logic             tok_done,
   output logic [CNT_W-1:0] tok_count
);

   localparam int D_SAT = (MAX_DIGIT == 0) ? 1 : MAX_DIGIT + 1;
   localparam int AW    = $clog2(MIN_ALPHA + 1);
   localparam int DW    = $clog2(D_SAT + 1);

   localparam logic [AW-1:0] A_SAT_V = AW'(MIN_ALPHA);
   localparam logic [DW-1:0] D_SAT_V = DW'(D_SAT);
   localparam logic [DW-1:0] D_MAX_V = DW'(MAX_DIGIT);

   char_cls_t        cls;
   state_t           state_reg,     state_next;
   logic [AW-1:0]    alpha_cnt_reg, alpha_cnt_next;
   logic [DW-1:0]    digit_cnt_reg, digit_cnt_next;
   logic             out_reg,       out_next;
   logic             tok_done_reg;
   logic [CNT_W-1:0] tok_count_reg;
   logic             tok_end;

   char_class #(
      .UNDERSCORE_ALPHA (UNDERSCORE_ALPHA)
   ) u_char_class (
      .char (char),
      .cls  (cls)
   );

   always_comb begin
      state_next     = state_reg;
      alpha_cnt_next = alpha_cnt_reg;
      digit_cnt_next = digit_cnt_reg;
      unique case (state_reg)
         S_IDLE: begin
            if (cls == CLS_ALPHA) begin
               state_next     = S_ALPHA;
               alpha_cnt_next = AW'(1);
            end else if ((cls == CLS_DIGIT) && (STRICT != 0)) begin
               state_next = S_BAD;
            end else begin
               state_next = S_IDLE;
            end
         end
         S_ALPHA: begin
            if (cls == CLS_ALPHA) begin
               if (alpha_cnt_reg != A_SAT_V) begin
                  alpha_cnt_next = alpha_cnt_reg + AW'(1);
               end
            end else if (cls == CLS_DIGIT) begin
               if (alpha_cnt_reg >= A_SAT_V) begin
                  state_next     = S_DIGIT;
                  digit_cnt_next = DW'(1);
               end else if (STRICT != 0) begin
                  state_next = S_BAD;
               end else begin
                  state_next = S_IDLE;
               end
            end else begin
               state_next = S_IDLE;
            end
         end
         S_DIGIT: begin
            if (cls == CLS_DIGIT) begin
               // A suffix that grows past MAX_DIGIT parks at MAX_DIGIT+1 so out stays low
               if ((MAX_DIGIT != 0) && (digit_cnt_reg >= D_MAX_V)) begin
                  if (STRICT != 0) begin
                     state_next = S_BAD;
                  end else begin
                     digit_cnt_next = D_SAT_V;
                  end
               end else if (digit_cnt_reg != D_SAT_V) begin
                  digit_cnt_next = digit_cnt_reg + DW'(1);
               end
            end else if (cls == CLS_ALPHA) begin
               if (STRICT != 0) begin
                  state_next = S_BAD;
               end else begin
                  state_next     = S_ALPHA;
                  alpha_cnt_next = AW'(1);
                  digit_cnt_next = '0;
               end
            end else begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = (cls == CLS_SEP) ? S_IDLE : S_BAD;
         end
      endcase
      if ((state_next == S_IDLE) || (state_next == S_BAD)) begin
         alpha_cnt_next = '0;
         digit_cnt_next = '0;
      end
   end

   assign out_next = (state_next == S_DIGIT)
                  && ((MAX_DIGIT == 0) || (digit_cnt_next <= D_MAX_V));
   assign tok_end  = (cls == CLS_SEP) && out_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= S_IDLE;
         alpha_cnt_reg <= '0;
         digit_cnt_reg <= '0;
         out_reg       <= 1'b0;
         tok_done_reg  <= 1'b0;
         tok_count_reg <= '0;
      end else if (char_valid) begin
         state_reg     <= state_next;
         alpha_cnt_reg <= alpha_cnt_next;
         digit_cnt_reg <= digit_cnt_next;
         out_reg       <= out_next;
         tok_done_reg  <= tok_end;
         if (tok_end && (tok_count_reg != {CNT_W{1'b1}})) begin
            tok_count_reg <= tok_count_reg + CNT_W'(1);
         end
      end else begin
         tok_done_reg <= 1'b0;
      end
   end

   assign out       = out_reg;
   assign tok_done  = tok_done_reg;
   assign tok_count = tok_count_reg;

endmodule

// File: tb/tb_id_scan_fsm.sv
// Scoreboard bench for id_scan_fsm: five parameterisations share one character
// stream; each transaction's expectations are queued at drive time and checked after the edge.
module tb_id_scan_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic       char_valid;
   logic [7:0] char;

   logic [4:0] out_v;
   logic [4:0] done_v;
   logic [7:0] cnt0, cnt1, cnt2, cnt4;
   logic [1:0] cnt3;

   typedef struct {
      int         dut;
      logic       out;
      logic       done;
      logic [7:0] cnt;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   id_scan_fsm u_def (
      .clk(clk), .reset(reset), .char_valid(char_valid), .char(char),
      .out(out_v[0]), .tok_done(done_v[0]), .tok_count(cnt0));

   id_scan_fsm #(.STRICT(1)) u_strict (
      .clk(clk), .reset(reset), .char_valid(char_valid), .char(char),
      .out(out_v[1]), .tok_done(done_v[1]), .tok_count(cnt1));

   id_scan_fsm #(.MIN_ALPHA(2), .MAX_DIGIT(2)) u_bounds (
      .clk(clk), .reset(reset), .char_valid(char_valid), .char(char),
      .out(out_v[2]), .tok_done(done_v[2]), .tok_count(cnt2));

   id_scan_fsm #(.CNT_W(2)) u_cnt2 (
      .clk(clk), .reset(reset), .char_valid(char_valid), .char(char),
      .out(out_v[3]), .tok_done(done_v[3]), .tok_count(cnt3));

   id_scan_fsm #(.UNDERSCORE_ALPHA(1)) u_us (
      .clk(clk), .reset(reset), .char_valid(char_valid), .char(char),
      .out(out_v[4]), .tok_done(done_v[4]), .tok_count(cnt4));

   function automatic logic [7:0] get_cnt(input int d);
      case (d)
         0:       return cnt0;
         1:       return cnt1;
         2:       return cnt2;
         3:       return {6'd0, cnt3};
         default: return cnt4;
      endcase
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input logic v, input logic [7:0] c);
      @(negedge clk);
      reset      = 1'b1;
      char_valid = v;
      char       = c;
      @(posedge clk);
      #1;
      for (int d = 0; d < 5; d++) begin
         check_val($sformatf("rst d%0d out", d),  {31'd0, out_v[d]},  32'd0);
         check_val($sformatf("rst d%0d done", d), {31'd0, done_v[d]}, 32'd0);
         check_val($sformatf("rst d%0d cnt", d),  {24'd0, get_cnt(d)}, 32'd0);
      end
      $display("reset v=%0b ch=%02h", v, c);
      @(negedge clk);
      reset      = 1'b0;
      char_valid = 1'b0;
   endtask

   task automatic step(input int dut, input logic v, input logic [7:0] c,
                       input logic eo, input logic ed, input int ec);
      exp_t e;
      @(negedge clk);
      char_valid = v;
      char       = c;
      e.dut  = dut;
      e.out  = eo;
      e.done = ed;
      e.cnt  = 8'(ec);
      e.tag  = $sformatf("d%0d #%0d ch=%02h v=%0b", dut, n_checks / 3, c, v);
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_val({e.tag, " out"},  {31'd0, out_v[e.dut]},  {31'd0, e.out});
      check_val({e.tag, " done"}, {31'd0, done_v[e.dut]}, {31'd0, e.done});
      check_val({e.tag, " cnt"},  {24'd0, get_cnt(e.dut)}, {24'd0, e.cnt});
      $display("d%0d v=%0b ch=%02h out=%0b done=%0b cnt=%0d",
               e.dut, v, c, out_v[e.dut], done_v[e.dut], get_cnt(e.dut));
   endtask

   // Expected out/done/count per character are given as digit strings.
   task automatic run_str(input int dut, input string s, input string eo,
                          input string ed, input string ec);
      for (int i = 0; i < s.len(); i++) begin
         step(dut, 1'b1, s[i], eo[i] == 8'd49, ed[i] == 8'd49, int'(ec[i]) - 48);
      end
   endtask

   initial begin
      reset      = 1'b0;
      char_valid = 1'b0;
      char       = 8'd0;

      do_reset(1'b0, 8'd0);
      run_str(0, "ab12  ", "001100", "000010", "000011");

      do_reset(1'b0, 8'd0);
      run_str(0, "1a1", "001", "000", "000");

      do_reset(1'b0, 8'd0);
      run_str(1, "1a1 x9", "000001", "000000", "000000");

      do_reset(1'b0, 8'd0);
      run_str(2, "a1 ab123 ab12;", "00000110000110", "00000000000001", "00000000000001");

      do_reset(1'b0, 8'd0);
      step(0, 1'b1, "a", 1'b0, 1'b0, 0);
      step(0, 1'b0, "?", 1'b0, 1'b0, 0);
      step(0, 1'b0, "?", 1'b0, 1'b0, 0);
      step(0, 1'b1, "5", 1'b1, 1'b0, 0);
      step(0, 1'b0, "?", 1'b1, 1'b0, 0);
      step(0, 1'b1, " ", 1'b0, 1'b1, 1);
      step(0, 1'b0, " ", 1'b0, 1'b0, 1);

      do_reset(1'b0, 8'd0);
      run_str(3, "a1 a1 a1 a1 a1 ", "010010010010010", "001001001001001", "001112223333333");

      do_reset(1'b0, 8'd0);
      run_str(0, "a1 ab1", "010001", "001000", "001111");
      do_reset(1'b1, "x");
      step(0, 1'b1, " ", 1'b0, 1'b0, 0);

      do_reset(1'b0, 8'd0);
      run_str(4, "_9", "01", "00", "00");
      do_reset(1'b0, 8'd0);
      run_str(0, "_9", "00", "00", "00");

      do_reset(1'b0, 8'd0);
      run_str(0, "Az0/@a9[^9{z:0", "00100010000000", "00010001000000", "00011112222222");

      if (sb.size() != 0) begin
         check_val("scoreboard drained", sb.size(), 32'd0);
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
